load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for mem_ready per memory phase.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: request from the execute stage is valid.
REQ-005 SHALL have port req_ready, output, 1: unit accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned, input, 1: loads zero-extend when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: consumer takes the response.
REQ-013 SHALL have port rsp_rdata, output, 32: formatted load data.
REQ-014 SHALL have port rsp_err, output, 1: misaligned/illegal size or memory timeout.
REQ-015 SHALL have ports mem_read (output, 1), mem_write (output, 1), mem_address (output, 32, word index = {2'b00, req_addr[31:2]}), mem_write_data (output, 32), mem_read_data (input, 32) and mem_ready (input, 1), connecting to the word-addressed data memory.

Function
REQ-016 SHALL implement states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP.
REQ-017 SHALL assert req_ready only in IDLE; handshake = req_valid & req_ready; all request fields latched on handshake.
REQ-018 SHALL, on handshake of a misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size 11, go directly to RESP with rsp_err=1, rsp_rdata=0, no memory strobe.
REQ-019 SHALL route loads IDLE->RD_ISSUE->RD_WAIT->RESP, word stores IDLE->WR_ISSUE->WR_WAIT->RESP, byte/half stores (read-modify-write) IDLE->RD_ISSUE->RD_WAIT->WR_ISSUE->WR_WAIT->RESP.
REQ-020 SHALL hold mem_read=1 in RD_ISSUE/RD_WAIT and mem_write=1 in WR_ISSUE/WR_WAIT, both 0 elsewhere; never both 1.
REQ-021 SHALL ignore mem_ready in *_ISSUE states (stale ready from a prior phase) and leave ISSUE after exactly one cycle.
REQ-022 SHALL, in RD_WAIT with mem_ready=1, capture mem_read_data; in WR_WAIT with mem_ready=1, complete the write.
REQ-023 SHALL count cycles in each WAIT state; if mem_ready is not seen within TIMEOUT_CYCLES cycles, drop the strobe, go to RESP with rsp_err=1, rsp_rdata=0.
REQ-024 SHALL format loads: lane = addr[1:0]; byte = word[8*lane+7:8*lane], half = word[16*addr[1]+15:16*addr[1]]; extended per req_unsigned.
REQ-025 SHALL merge sub-word stores into the captured word at the same lane, other bytes unchanged; mem_write_data = merged word (word store: req_wdata).
REQ-026 SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err in RESP until rsp_ready=1, then return to IDLE the next cycle; store responses carry rsp_rdata=0.
REQ-027 SHALL, with a 1-cycle memory, give rsp_valid 3 cycles after handshake for loads and word stores, 5 for sub-word stores.
REQ-028 SHALL not accept a new request in RESP even if rsp_ready=1 (back-to-back spacing of at least one IDLE cycle).

Reset
REQ-029 SHALL, while rst=0, force state IDLE, wait counter 0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, asynchronously, including mid-operation.
REQ-030 SHALL assert req_ready in the first cycle after rst deasserts; aborted transactions produce no response.

Verification
REQ-031 SHALL verify word load addr 0x10 with memory word 4 = 0x8081_8283 -> rsp_rdata 0x8081_8283, rsp_err 0, rsp_valid in cycle 3.
REQ-032 SHALL verify byte load addr 0x11, signed, same word -> rsp_rdata 0xFFFF_FF82; unsigned -> 0x0000_0082.
REQ-033 SHALL verify half store 0xBEEF to addr 0x12 with word 4 = 0x1122_3344 -> word 4 becomes 0xBEEF_3344, rsp_valid in cycle 5, mem_read then mem_write, never overlapping.
REQ-034 SHALL verify word load addr 0x13 -> rsp_err 1 in cycle 1, mem_read/mem_write never asserted.
REQ-035 SHALL verify mem_ready tied 0 on a load -> rsp_err 1 after TIMEOUT_CYCLES wait cycles, mem_read dropped; rsp_ready held 0 for 4 cycles keeps response stable.
REQ-036 SHALL verify rst=0 asserted in RD_WAIT -> mem_read and rsp_valid 0 immediately, no response after release, req_ready 1 next cycle.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bundle for the load/store unit.
// slave = the load/store unit itself; master = execute stage plus memory.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ready;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_read_data, mem_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_read_data, mem_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores to a word-addressed memory,
// sub-word stores done as read-modify-write, with a per-phase ready timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    lane_q, lane_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [31:0]   mem_address_q, mem_address_d;
    logic [31:0]   mem_write_data_q, mem_write_data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          req_ready_w;
    logic          handshake;
    logic          misaligned;
    logic [31:0]   byte_shift;
    logic [31:0]   half_shift;
    logic [31:0]   load_data;
    logic [31:0]   wdata_rep;
    logic [31:0]   merged;
    logic [3:0]    lane_hit;

    // Held low while reset is active even though the state register already reads IDLE.
    assign req_ready_w = rst & (state_q == IDLE);
    assign handshake   = bus.req_valid & req_ready_w;

    assign misaligned = (bus.req_size == 2'b11)
                      | ((bus.req_size == 2'b01) & bus.req_addr[0])
                      | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));

    assign byte_shift = bus.mem_read_data >> {lane_q, 3'b000};
    assign half_shift = bus.mem_read_data >> {lane_q[1], 4'b0000};

    always_comb begin
        load_data = bus.mem_read_data;
        case (size_q)
            2'b00:   load_data = {{24{~uns_q & byte_shift[7]}}, byte_shift[7:0]};
            2'b01:   load_data = {{16{~uns_q & half_shift[15]}}, half_shift[15:0]};
            default: load_data = bus.mem_read_data;
        endcase
    end

    assign wdata_rep = (size_q == 2'b00) ? {4{wdata_q[7:0]}} : {2{wdata_q}};

    // Byte-lane merge of store data into the word just read back.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_hit[gi] = (size_q == 2'b00) ? (lane_q == LANE)
                                                    : (lane_q[1] == LANE[1]);
            assign merged[8*gi +: 8] = lane_hit[gi] ? wdata_rep[8*gi +: 8]
                                                    : bus.mem_read_data[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        we_d             = we_q;
        size_d           = size_q;
        uns_d            = uns_q;
        lane_d           = lane_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        rdata_d          = rdata_q;
        err_d            = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (handshake) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata[15:0];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        mem_address_d = {2'b00, bus.req_addr[31:2]};
                        if (bus.req_we && (bus.req_size == 2'b10)) begin
                            mem_write_data_d = bus.req_wdata;
                            state_d          = WR_ISSUE;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: begin
                cnt_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.mem_ready) begin
                    cnt_d = '0;
                    if (we_q) begin
                        mem_write_data_d = merged;
                        state_d          = WR_ISSUE;
                    end else begin
                        rdata_d = load_data;
                        state_d = RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_ISSUE: begin
                cnt_d   = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.mem_ready) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            we_q             <= 1'b0;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            rdata_q          <= '0;
            err_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            we_q             <= we_d;
            size_q           <= size_d;
            uns_q            <= uns_d;
            lane_q           <= lane_d;
            wdata_q          <= wdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            rdata_q          <= rdata_d;
            err_q            <= err_d;
        end
    end

    assign bus.req_ready      = req_ready_w;
    assign bus.rsp_valid      = (state_q == RESP);
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_err        = err_q;
    assign bus.mem_read       = (state_q == RD_ISSUE) | (state_q == RD_WAIT);
    assign bus.mem_write      = (state_q == WR_ISSUE) | (state_q == WR_WAIT);
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_write_data = mem_write_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-lane arithmetic model
// of the memory, plus directed cases for the documented corner behaviours.
module tb_load_store_unit;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    bit          stall   = 1'b0;
    bit          pre_we  = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    // One-cycle memory: ready follows a strobe by one cycle unless stalled.
    always @(posedge clk) begin
        bus.mem_ready     <= !stall && (bus.mem_read || bus.mem_write);
        bus.mem_read_data <= mem[bus.mem_address[5:0]];
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (bus.mem_write && !stall)
            mem[bus.mem_address[5:0]] <= bus.mem_write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = 6'(idx);
        pre_data = data;
        ref_mem[idx] = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    function automatic bit is_illegal(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (w >> (8 * (addr % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (size == 2'd2) return wd;
        if (size == 2'd0) begin
            sh   = 8 * int'(addr % 4);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((wd & 32'hFF) << sh);
        end
        sh   = 16 * int'((addr / 2) % 2);
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((wd & 32'hFFFF) << sh);
    endfunction

    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input bit stl, input int hold);
        bit          illegal, sub, exp_err, exp_rd, exp_wr;
        int          exp_lat, lat, guard, idx, rd_last, wr_first;
        bit          rd_seen, wr_seen;
        logic [31:0] exp_rdata;

        illegal   = is_illegal(size, addr);
        idx       = int'((addr / 4) % 64);
        sub       = we && (size != 2'd2);
        exp_err   = illegal || stl;
        exp_lat   = illegal ? 1 : (stl ? 2 + T : (sub ? 5 : 3));
        exp_rd    = !illegal && (!we || sub);
        exp_wr    = !illegal && we && (size == 2'd2 || !stl);
        exp_rdata = (exp_err || we) ? 32'h0 : ref_load(ref_mem[idx], size, uns, addr);

        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_eq("req_ready_idle", {31'b0, bus.req_ready}, 32'h1);

        stall            = stl;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        lat = 0; rd_seen = 0; wr_seen = 0; rd_last = 0; wr_first = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            check_eq("no_overlap", {31'b0, bus.mem_read & bus.mem_write}, 32'h0);
            if (bus.mem_read) begin
                rd_seen = 1; rd_last = c;
                check_eq("rd_addr", bus.mem_address, addr >> 2);
            end
            if (bus.mem_write) begin
                if (!wr_seen) wr_first = c;
                wr_seen = 1;
                check_eq("wr_addr", bus.mem_address, addr >> 2);
            end
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) begin
            check_eq("rsp_missing", 32'h0, 32'h1);
            stall = 1'b0;
            return;
        end

        $display("txn we=%0d size=%0d uns=%0d addr=0x%08h wdata=0x%08h stall=%0d -> lat=%0d err=%0d rdata=0x%08h",
                 we, size, uns, addr, wdata, stl, lat, bus.rsp_err, bus.rsp_rdata);
        check_eq("latency", lat, exp_lat);
        check_eq("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
        check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
        check_eq("rd_seen", {31'b0, rd_seen}, {31'b0, exp_rd});
        check_eq("wr_seen", {31'b0, wr_seen}, {31'b0, exp_wr});
        if (exp_rd && exp_wr)
            check_eq("rd_before_wr", {31'b0, rd_last < wr_first}, 32'h1);
        check_eq("strobes_in_resp", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
        check_eq("no_ready_in_resp", {31'b0, bus.req_ready}, 32'h0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", {31'b0, bus.rsp_valid}, 32'h1);
            check_eq("hold_rdata", bus.rsp_rdata, exp_rdata);
            check_eq("hold_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
        end

        // Release the response while offering a legal load that must not be taken.
        bus.rsp_ready    = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd2;
        bus.req_addr     = 32'h0;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        stall         = 1'b0;
        @(negedge clk);
        check_eq("no_accept_in_resp", {30'b0, bus.mem_read | bus.mem_write, bus.rsp_valid}, 32'h0);
        check_eq("idle_ready", {31'b0, bus.req_ready}, 32'h1);

        if (we && !exp_err) ref_mem[idx] = ref_store(ref_mem[idx], size, addr, wdata);
        if (we) check_eq("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [1:0] sz;
        int         r;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", {31'b0, bus.req_ready}, 32'h0);
        check_eq("rst_rsp", {30'b0, bus.rsp_valid, bus.rsp_err}, 32'h0);
        check_eq("rst_rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst_strobes", {30'b0, bus.mem_read, bus.mem_write}, 32'h0);
        check_eq("rst_mem_addr", bus.mem_address, 32'h0);
        check_eq("rst_mem_wdata", bus.mem_write_data, 32'h0);
        rst = 1'b1;
        #1 check_eq("ready_after_rst", {31'b0, bus.req_ready}, 32'h1);

        for (int i = 0; i < 64; i++) set_word(i, $urandom);

        // Directed cases
        set_word(4, 32'h8081_8283);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 1);
        run_txn(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 0);
        set_word(4, 32'h1122_3344);
        run_txn(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0, 0);
        check_eq("half_store_word", mem[4], 32'hBEEF_3344);
        run_txn(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b0, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 4);

        // Reset while waiting for a stalled read
        @(negedge clk);
        stall = 1'b1;
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h20; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_mem_read", {31'b0, bus.mem_read}, 32'h1);
        #1 rst = 1'b0;
        #1;
        check_eq("midrst_mem_read", {31'b0, bus.mem_read}, 32'h0);
        check_eq("midrst_rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
        check_eq("midrst_req_ready", {31'b0, bus.req_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        #1 check_eq("postrst_req_ready", {31'b0, bus.req_ready}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("postrst_no_rsp", {30'b0, bus.rsp_valid, bus.mem_read}, 32'h0);
        end

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 255)), $urandom,
                    ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
